jstk_fire_conditioner: RTL

Upstream stage feeding the bullet spawn logic. It consumes raw 40-bit PmodJSTK packets and produces registered aim coordinates, a dead-zone flag and a debounced fire event. The fire event carries a signed per-tick bullet velocity (dx, dy) and is delivered over a valid/ready handshake. The game logic therefore receives one clean, rate-limited shot request per button press instead of sampling raw button and axis bits itself.

---
 rtl/jstk_fire_conditioner.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/jstk_fire_conditioner.sv
// PmodJSTK packet conditioner: registered aim, dead-zone flag, debounced button and a
// rate-limited fire request on valid/ready. Define JSTK_AUTOFIRE_EN to re-fire on a held button.
module jstk_fire_conditioner #(
    parameter int unsigned CENTER          = 512,
    parameter int unsigned DEAD_ZONE       = 100,
    parameter int unsigned MAX_SPEED       = 5,
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned COOLDOWN_CYCLES = 2500000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [39:0] jstk_data,
    input  logic        jstk_valid,
    input  logic        fire_ready,
    output logic        fire_valid,
    output logic [7:0]  fire_dx,
    output logic [7:0]  fire_dy,
    output logic [9:0]  aim_x,
    output logic [9:0]  aim_y,
    output logic        aim_active,
    output logic        btn_db,
    output logic [7:0]  shot_count
);

    localparam int unsigned AXIS_W = 10;
    localparam int unsigned DIFF_W = 11;
    localparam int unsigned MAG_W  = 22;
    localparam int unsigned VEL_W  = 8;
    localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam int unsigned CD_W   = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES + 1) : 1;

    localparam logic [MAG_W-1:0]  DZ_SQ    = MAG_W'(DEAD_ZONE * DEAD_ZONE);
    localparam logic [DB_W-1:0]   DB_LAST  = DB_W'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0);
    localparam logic [CD_W-1:0]   CD_LOAD  = CD_W'((COOLDOWN_CYCLES > 0) ? COOLDOWN_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_OFFER    = 2'd1,
        ST_COOLDOWN = 2'd2
    } state_t;

    // Capture stage
    logic [AXIS_W-1:0] cap_x;
    logic [AXIS_W-1:0] cap_y;
    logic              btn_raw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_x   <= '0;
            cap_y   <= '0;
            btn_raw <= 1'b0;
        end else if (jstk_valid) begin
            cap_x   <= {jstk_data[9:8], jstk_data[23:16]};
            cap_y   <= {jstk_data[25:24], jstk_data[39:32]};
            btn_raw <= jstk_data[0];
        end
    end

    logic unused_jstk_bits_c;
    assign unused_jstk_bits_c = ^{jstk_data[31:26], jstk_data[15:10], jstk_data[7:1]};

    // Math stage: signed deflection, squared radius and truncated-toward-zero velocity
    logic signed [DIFF_W-1:0] dx_c, dy_c;
    logic [DIFF_W-1:0]        adx_c, ady_c;
    logic [MAG_W-1:0]         mag2_c;
    logic [VEL_W-1:0]         sx_c, sy_c, vx_c, vy_c;

    assign dx_c   = $signed({1'b0, cap_x}) - $signed(DIFF_W'(CENTER));
    assign dy_c   = $signed({1'b0, cap_y}) - $signed(DIFF_W'(CENTER));
    assign adx_c  = dx_c[DIFF_W-1] ? DIFF_W'(-dx_c) : DIFF_W'(dx_c);
    assign ady_c  = dy_c[DIFF_W-1] ? DIFF_W'(-dy_c) : DIFF_W'(dy_c);
    assign mag2_c = MAG_W'(adx_c) * MAG_W'(adx_c) + MAG_W'(ady_c) * MAG_W'(ady_c);
    assign sx_c   = VEL_W'((MAG_W'(adx_c) * MAG_W'(MAX_SPEED)) >> 9);
    assign sy_c   = VEL_W'((MAG_W'(ady_c) * MAG_W'(MAX_SPEED)) >> 9);
    assign vx_c   = dx_c[DIFF_W-1] ? VEL_W'(-sx_c) : sx_c;
    assign vy_c   = dy_c[DIFF_W-1] ? VEL_W'(-sy_c) : sy_c;

    logic [VEL_W-1:0] vx_q, vy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aim_x      <= '0;
            aim_y      <= '0;
            aim_active <= 1'b0;
            vx_q       <= '0;
            vy_q       <= '0;
        end else begin
            aim_x      <= cap_x;
            aim_y      <= cap_y;
            aim_active <= (mag2_c > DZ_SQ);
            vx_q       <= vx_c;
            vy_q       <= vy_c;
        end
    end

    // Debounce: the raw level must disagree for DEBOUNCE_CYCLES consecutive cycles
    logic [DB_W-1:0] db_cnt;
    logic            btn_db_q;
    logic            btn_rise_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt   <= '0;
            btn_db   <= 1'b0;
            btn_db_q <= 1'b0;
        end else begin
            btn_db_q <= btn_db;
            if (btn_raw != btn_db) begin
                if (db_cnt == DB_LAST) begin
                    btn_db <= ~btn_db;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    assign btn_rise_c = btn_db & ~btn_db_q;

    // Shot FSM
    state_t           state, state_nxt;
    logic             fire_valid_nxt;
    logic [VEL_W-1:0] fire_dx_nxt, fire_dy_nxt;
    logic [7:0]       shot_count_nxt;
    logic [CD_W-1:0]  cd_cnt, cd_cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            fire_valid <= 1'b0;
            fire_dx    <= '0;
            fire_dy    <= '0;
            shot_count <= '0;
            cd_cnt     <= '0;
        end else begin
            state      <= state_nxt;
            fire_valid <= fire_valid_nxt;
            fire_dx    <= fire_dx_nxt;
            fire_dy    <= fire_dy_nxt;
            shot_count <= shot_count_nxt;
            cd_cnt     <= cd_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        fire_valid_nxt = fire_valid;
        fire_dx_nxt    = fire_dx;
        fire_dy_nxt    = fire_dy;
        shot_count_nxt = shot_count;
        cd_cnt_nxt     = cd_cnt;
        unique case (state)
            ST_IDLE: begin
                if (btn_rise_c && aim_active) begin
                    state_nxt      = ST_OFFER;
                    fire_valid_nxt = 1'b1;
                    fire_dx_nxt    = vx_q;
                    fire_dy_nxt    = vy_q;
                end
            end
            ST_OFFER: begin
                if (fire_valid && fire_ready) begin
                    state_nxt      = ST_COOLDOWN;
                    fire_valid_nxt = 1'b0;
                    cd_cnt_nxt     = CD_LOAD;
                    if (shot_count != 8'hFF) begin
                        shot_count_nxt = shot_count + 8'd1;
                    end
                end
            end
            ST_COOLDOWN: begin
                if (cd_cnt == '0) begin
`ifdef JSTK_AUTOFIRE_EN
                    if (btn_db && aim_active) begin
                        state_nxt      = ST_OFFER;
                        fire_valid_nxt = 1'b1;
                        fire_dx_nxt    = vx_q;
                        fire_dy_nxt    = vy_q;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
`else
                    state_nxt = ST_IDLE;
`endif
                end else begin
                    cd_cnt_nxt = cd_cnt - CD_W'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule
